// File: rtl/eth_rx_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : eth_rx_bank_ctrl
// Description : Two-bank receive buffer controller. It selects the bank the
//               receiver writes, commits or discards each frame, and hands
//               completed frames to the CPU in arrival order.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_rx_bank_ctrl #(
    parameter int MIN_LEN = 14,
    parameter int MAX_LEN = 1536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss,
    input  logic        wr_stb,
    input  logic        n_inhibit,
    input  logic        cpu_release,
    output logic        recv_ena,
    output logic        wr_bank,
    output logic        rd_bank,
    output logic        frame_avail,
    output logic [10:0] rd_len,
    output logic [7:0]  overrun_cnt
);

    localparam logic [10:0] MIN_LEN_W = 11'(MIN_LEN);
    localparam logic [10:0] MAX_LEN_W = 11'(MAX_LEN);
    localparam logic [10:0] CNT_SAT   = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        RECV   = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        ss_q;
    logic        rise;
    logic        fall;
    logic [1:0]  full;
    logic [1:0]  full_next;
    logic [10:0] len [2];
    logic        wr_bank_next;
    logic [10:0] byte_cnt;
    logic        drop;
    logic        accept;
    logic        release_ok;

    assign rise        = ss & ~ss_q;
    assign fall        = ~ss & ss_q;
    assign frame_avail = full[rd_bank];
    assign rd_len      = len[rd_bank];

    always_comb begin
        state_next   = state;
        recv_ena     = 1'b0;
        accept       = 1'b0;
        release_ok   = cpu_release & full[rd_bank];
        full_next    = full;
        wr_bank_next = wr_bank;
        case (state)
            IDLE: begin
                if (!full[wr_bank]) state_next = ARMED;
            end
            ARMED: begin
                recv_ena = 1'b1;
                if (rise) state_next = RECV;
            end
            RECV: begin
                recv_ena = 1'b1;
                if (fall) state_next = COMMIT;
            end
            COMMIT: begin
                recv_ena = 1'b1;
                accept   = !drop && (byte_cnt >= MIN_LEN_W) && (byte_cnt <= MAX_LEN_W);
            end
            default: state_next = IDLE;
        endcase
        if (accept) begin
            full_next[wr_bank] = 1'b1;
            wr_bank_next       = ~wr_bank;
        end
        if (release_ok) full_next[rd_bank] = 1'b0;
        // A release in the commit cycle may free the bank we move on to.
        if (state == COMMIT) state_next = full_next[wr_bank_next] ? IDLE : ARMED;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ss_q        <= 1'b0;
            full        <= 2'b00;
            len         <= '{default: '0};
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            byte_cnt    <= '0;
            drop        <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            state   <= state_next;
            ss_q    <= ss;
            full    <= full_next;
            wr_bank <= wr_bank_next;
            if (accept)     len[wr_bank] <= byte_cnt;
            if (release_ok) rd_bank      <= ~rd_bank;
            case (state)
                IDLE: begin
                    if (rise && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
                end
                ARMED: begin
                    if (rise) begin
                        byte_cnt <= '0;
                        drop     <= 1'b0;
                    end
                end
                RECV: begin
                    if (wr_stb && byte_cnt != CNT_SAT) byte_cnt <= byte_cnt + 11'd1;
                    if (!n_inhibit) drop <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_eth_rx_bank_ctrl
// Description : Directed self-checking bench for eth_rx_bank_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eth_rx_bank_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ss = 1'b0;
    logic        wr_stb = 1'b0;
    logic        n_inhibit = 1'b1;
    logic        cpu_release = 1'b0;
    logic        recv_ena;
    logic        wr_bank;
    logic        rd_bank;
    logic        frame_avail;
    logic [10:0] rd_len;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int passed = 0;

    eth_rx_bank_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .ss          (ss),
        .wr_stb      (wr_stb),
        .n_inhibit   (n_inhibit),
        .cpu_release (cpu_release),
        .recv_ena    (recv_ena),
        .wr_bank     (wr_bank),
        .rd_bank     (rd_bank),
        .frame_avail (frame_avail),
        .rd_len      (rd_len),
        .overrun_cnt (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Frame of nbytes strobes; the last strobe coincides with the ss fall.
    // Returns one cycle after the commit cycle, when results are visible.
    task automatic send_frame(input int nbytes, input int drop_at, input bit rel_at_commit);
        ss = 1'b1;
        tick(1);
        for (int i = 0; i < nbytes - 1; i++) begin
            wr_stb    = 1'b1;
            n_inhibit = (i == drop_at) ? 1'b0 : 1'b1;
            tick(1);
        end
        wr_stb    = 1'b1;
        n_inhibit = 1'b1;
        ss        = 1'b0;
        tick(1);
        wr_stb      = 1'b0;
        cpu_release = rel_at_commit;
        tick(1);
        cpu_release = 1'b0;
    endtask

    task automatic release_once();
        cpu_release = 1'b1;
        tick(1);
        cpu_release = 1'b0;
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        chk("reset_recv_ena", recv_ena, 0);
        chk("reset_wr_bank", wr_bank, 0);
        chk("reset_rd_bank", rd_bank, 0);
        chk("reset_avail", frame_avail, 0);
        chk("reset_rd_len", rd_len, 0);
        chk("reset_overrun", overrun_cnt, 0);
        tick(1);
        chk("armed_after_reset", recv_ena, 1);

        send_frame(20, -1, 1'b0);
        chk("f20_avail", frame_avail, 1);
        chk("f20_len", rd_len, 20);
        chk("f20_rd_bank", rd_bank, 0);
        chk("f20_wr_bank", wr_bank, 1);
        release_once();
        chk("rel1_avail", frame_avail, 0);
        chk("rel1_rd_bank", rd_bank, 1);

        send_frame(20, 2, 1'b0);
        chk("drop_avail", frame_avail, 0);
        chk("drop_wr_bank", wr_bank, 1);
        chk("drop_recv_ena", recv_ena, 1);

        send_frame(13, -1, 1'b0);
        chk("short_avail", frame_avail, 0);
        send_frame(1537, -1, 1'b0);
        chk("long_avail", frame_avail, 0);
        chk("long_wr_bank", wr_bank, 1);

        send_frame(14, -1, 1'b0);
        chk("min_avail", frame_avail, 1);
        chk("min_len", rd_len, 14);
        chk("min_wr_bank", wr_bank, 0);
        send_frame(1536, -1, 1'b0);
        chk("max_wr_bank", wr_bank, 1);
        chk("max_rd_len_before_rel", rd_len, 14);
        release_once();
        chk("max_len", rd_len, 1536);
        chk("max_rd_bank", rd_bank, 0);
        release_once();
        chk("empty_avail", frame_avail, 0);
        chk("len_held", rd_len, 14);

        send_frame(30, -1, 1'b0);
        send_frame(40, -1, 1'b0);
        chk("both_full_recv_ena", recv_ena, 0);
        chk("both_full_len", rd_len, 30);
        ss = 1'b1;
        tick(1);
        chk("overrun_one", overrun_cnt, 1);
        wr_stb = 1'b1;
        tick(3);
        wr_stb = 1'b0;
        ss = 1'b0;
        tick(1);
        release_once();
        chk("after_rel_len", rd_len, 40);
        chk("after_rel_still_idle", recv_ena, 0);
        tick(1);
        chk("after_rel_armed", recv_ena, 1);

        send_frame(25, -1, 1'b1);
        chk("simul_rd_bank", rd_bank, 1);
        chk("simul_avail", frame_avail, 1);
        chk("simul_len", rd_len, 25);
        chk("simul_wr_bank", wr_bank, 0);
        chk("simul_recv_ena", recv_ena, 1);
        release_once();
        release_once();
        chk("idle_rel_rd_bank", rd_bank, 0);
        chk("idle_rel_avail", frame_avail, 0);
        chk("idle_rel_wr_bank", wr_bank, 0);

        ss = 1'b1;
        tick(1);
        wr_stb = 1'b1;
        tick(5);
        wr_stb = 1'b0;
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk("midrst_recv_ena", recv_ena, 0);
        tick(1);
        chk("midrst_armed", recv_ena, 1);
        wr_stb = 1'b1;
        tick(20);
        wr_stb = 1'b0;
        ss = 1'b0;
        tick(3);
        chk("midrst_no_capture", frame_avail, 0);
        chk("midrst_wr_bank", wr_bank, 0);
        send_frame(20, -1, 1'b0);
        chk("midrst_next_len", rd_len, 20);

        send_frame(20, -1, 1'b0);
        chk("sat_full_recv_ena", recv_ena, 0);
        for (int i = 0; i < 300; i++) begin
            ss = 1'b1;
            tick(1);
            ss = 1'b0;
            tick(1);
        end
        chk("overrun_sat", overrun_cnt, 255);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
